// File: rtl/tx_ltssm_os_generator_if.sv
// Ordered-set handoff between the LTSSM transmit generator and the lane framer.
// The generator owns the set, its type and valid; the framer owns ready.
interface tx_ltssm_os_generator_if;
    logic [2047:0] orderedSets;
    logic          os_valid;
    logic [1:0]    os_type;
    logic          os_ready;

    modport master (
        output orderedSets,
        output os_valid,
        output os_type,
        input  os_ready
    );

    modport slave (
        input  orderedSets,
        input  os_valid,
        input  os_type,
        output os_ready
    );
endinterface

// File: rtl/tx_ltssm_os_generator.sv
// Per-lane TS1/TS2/EIOS ordered-set generator for the LTSSM transmit path.
// Defining TX_SKP_INSERT_EN adds periodic SKP insertion every SKP_INTERVAL data sets.
module tx_ltssm_os_generator #(
    parameter int DEVICETYPE   = 0,
    parameter int POLL_TS1_MIN = 1024,
    parameter int POST_RX_MIN  = 16
`ifdef TX_SKP_INSERT_EN
    ,
    parameter int SKP_INTERVAL = 1180
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  Gen,
    input  logic [3:0]  substate,
    input  logic        start,
    input  logic [7:0]  linkNumber,
    input  logic [7:0]  rxLinkNumber,
    input  logic [4:0]  numberOfDetectedLanes,
    input  logic [7:0]  rateId,
    input  logic        directed_speed_change,
    input  logic        rxDone,
    output logic        finish,
    output logic [10:0] sentCount,
    tx_ltssm_os_generator_if.master osIf
);

    localparam logic [10:0] POLL_MIN_C = 11'(POLL_TS1_MIN);
    localparam logic [10:0] POST_MIN_C = 11'(POST_RX_MIN);
    localparam logic [10:0] CNT_MAX_C  = 11'h7FF;
    localparam logic [1:0]  OS_TS1     = 2'd0;
    localparam logic [1:0]  OS_TS2     = 2'd1;
    localparam logic [1:0]  OS_EIOS    = 2'd2;
`ifdef TX_SKP_INSERT_EN
    localparam logic [1:0]  OS_SKP     = 2'd3;
    localparam logic [10:0] SKP_C      = 11'(SKP_INTERVAL);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t        state_r;
    state_t        nextState_s;
    logic [3:0]    substate_r;
    logic [10:0]   sentCount_r;
    logic [10:0]   postCnt_r;
    logic [10:0]   sentNext_s;
    logic [10:0]   postNext_s;
    logic          osValid_r;
    logic          finish_r;
    logic [1:0]    osType_r;
    logic [2047:0] orderedSets_r;
    logic          accept_s;
    logic          exitMet_s;
    logic [7:0]    linkField_s;
    logic [7:0]    rateSym_s;
    logic [2047:0] tsSet_s;
    logic          unusedRate_s;
`ifdef TX_SKP_INSERT_EN
    logic [10:0]   slotCnt_r;
    logic [10:0]   slotNext_s;
    logic          skpActive_r;
    logic          skpNext_s;
    logic [2047:0] skpSet_s;
`endif

    function automatic logic isTxSubstate(input logic [3:0] sub);
        return (sub >= 4'd1) && (sub <= 4'd7);
    endfunction

    function automatic logic [1:0] kindOf(input logic [3:0] sub);
        case (sub)
            4'd1, 4'd3, 4'd5: return OS_TS1;
            4'd2, 4'd4, 4'd6: return OS_TS2;
            default:          return OS_EIOS;
        endcase
    endfunction

    // Lane fields: Polling uses PAD for link and lane, CfgLinkWidth pads only the lane.
    function automatic logic [2047:0] buildOs(
        input logic [1:0] kind,
        input logic [3:0] sub,
        input logic [2:0] gen,
        input logic [7:0] link,
        input logic [4:0] lanes,
        input logic [7:0] rateSym
    );
        logic [2047:0]    os;
        logic [15:0][7:0] b;
        logic             hiRate;
        hiRate = (gen >= 3'd3);
        os     = '0;
        for (int i = 0; i < 16; i++) begin
            b = '0;
            case (kind)
                OS_TS1, OS_TS2: begin
                    b[0] = hiRate ? ((kind == OS_TS1) ? 8'h1E : 8'h2D) : 8'hBC;
                    b[1] = ((sub == 4'd1) || (sub == 4'd2)) ? 8'hF7 : link;
                    b[2] = (sub >= 4'd4) ? 8'(i) : 8'hF7;
                    b[3] = 8'hFF;
                    b[4] = rateSym;
                    b[5] = 8'h00;
                    for (int k = 6; k < 16; k++) begin
                        b[k] = (kind == OS_TS1) ? 8'h4A : 8'h45;
                    end
                end
                OS_EIOS: begin
                    if (hiRate) begin
                        for (int k = 0; k < 16; k++) begin
                            b[k] = 8'h66;
                        end
                    end else begin
                        b[0] = 8'hBC;
                        b[1] = 8'h7C;
                        b[2] = 8'h7C;
                        b[3] = 8'h7C;
                    end
                end
`ifdef TX_SKP_INSERT_EN
                OS_SKP: begin
                    if (hiRate) begin
                        for (int k = 0; k < 12; k++) begin
                            b[k] = 8'hAA;
                        end
                        b[12] = 8'hE1;
                    end else begin
                        b[0] = 8'hBC;
                        b[1] = 8'h1C;
                        b[2] = 8'h1C;
                        b[3] = 8'h1C;
                    end
                end
`endif
                default: b = '0;
            endcase
            if (5'(i) < lanes) begin
                os[i*128 +: 128] = b;
            end else begin
                os[i*128 +: 128] = '0;
            end
        end
        return os;
    endfunction

    assign linkField_s  = (DEVICETYPE == 0) ? linkNumber : rxLinkNumber;
    assign rateSym_s    = {directed_speed_change, rateId[6:0]};
    assign unusedRate_s = rateId[7];
    assign tsSet_s      = buildOs(kindOf(substate_r), substate_r, Gen, linkField_s,
                                  numberOfDetectedLanes, rateSym_s);
`ifdef TX_SKP_INSERT_EN
    assign skpSet_s     = buildOs(OS_SKP, substate_r, Gen, linkField_s,
                                  numberOfDetectedLanes, rateSym_s);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state decode, accept bookkeeping and substate exit check
    always_comb begin
        nextState_s = state_r;
        accept_s    = 1'b0;
        exitMet_s   = 1'b0;
        sentNext_s  = sentCount_r;
        postNext_s  = postCnt_r;
`ifdef TX_SKP_INSERT_EN
        slotNext_s  = slotCnt_r;
        skpNext_s   = 1'b0;
`endif
        if (start) begin
            nextState_s = isTxSubstate(substate) ? LOAD : IDLE;
        end else begin
            case (state_r)
                IDLE: nextState_s = IDLE;
                LOAD: nextState_s = SEND;
                SEND: begin
                    if (osValid_r && osIf.os_ready) begin
                        accept_s = 1'b1;
`ifdef TX_SKP_INSERT_EN
                        // An accepted SKP restarts the slot count and is invisible to the counters.
                        if (skpActive_r) begin
                            slotNext_s = '0;
                        end else begin
`endif
                        sentNext_s = (sentCount_r == CNT_MAX_C) ? CNT_MAX_C : sentCount_r + 11'd1;
                        if (rxDone) begin
                            postNext_s = (postCnt_r == CNT_MAX_C) ? CNT_MAX_C : postCnt_r + 11'd1;
                        end else begin
                            postNext_s = postCnt_r;
                        end
                        case (substate_r)
                            4'd1:             exitMet_s = rxDone && (sentNext_s >= POLL_MIN_C);
                            4'd4, 4'd6:       exitMet_s = (postNext_s >= POST_MIN_C);
                            4'd2, 4'd3, 4'd5: exitMet_s = rxDone;
                            default:          exitMet_s = 1'b1;
                        endcase
`ifdef TX_SKP_INSERT_EN
                        slotNext_s = slotCnt_r + 11'd1;
                        skpNext_s  = !exitMet_s && (substate_r != 4'd7) && (slotNext_s >= SKP_C);
                        end
`endif
                        nextState_s = exitMet_s ? IDLE : SEND;
                    end else begin
                        nextState_s = SEND;
                    end
                end
                default: nextState_s = IDLE;
            endcase
        end
    end

    // Output registers, counters and substate latch
    always_ff @(posedge clk) begin
        if (reset) begin
            substate_r    <= 4'd0;
            sentCount_r   <= '0;
            postCnt_r     <= '0;
            osValid_r     <= 1'b0;
            finish_r      <= 1'b0;
            osType_r      <= OS_TS1;
            orderedSets_r <= '0;
`ifdef TX_SKP_INSERT_EN
            slotCnt_r     <= '0;
            skpActive_r   <= 1'b0;
`endif
        end else if (start) begin
            substate_r  <= substate;
            sentCount_r <= '0;
            postCnt_r   <= '0;
            osValid_r   <= 1'b0;
            finish_r    <= !isTxSubstate(substate);
`ifdef TX_SKP_INSERT_EN
            slotCnt_r   <= '0;
            skpActive_r <= 1'b0;
`endif
        end else begin
            finish_r <= 1'b0;
            case (state_r)
                LOAD: begin
                    orderedSets_r <= tsSet_s;
                    osType_r      <= kindOf(substate_r);
                    osValid_r     <= 1'b1;
                end
                SEND: begin
                    if (accept_s) begin
                        sentCount_r <= sentNext_s;
                        postCnt_r   <= postNext_s;
`ifdef TX_SKP_INSERT_EN
                        slotCnt_r   <= slotNext_s;
                        skpActive_r <= skpNext_s;
`endif
                        if (exitMet_s) begin
                            osValid_r <= 1'b0;
                            finish_r  <= 1'b1;
                        end
`ifdef TX_SKP_INSERT_EN
                        else if (skpNext_s) begin
                            orderedSets_r <= skpSet_s;
                            osType_r      <= OS_SKP;
                        end
`endif
                        else begin
                            orderedSets_r <= tsSet_s;
                            osType_r      <= kindOf(substate_r);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign finish           = finish_r;
    assign sentCount        = sentCount_r;
    assign osIf.orderedSets = orderedSets_r;
    assign osIf.os_valid    = osValid_r;
    assign osIf.os_type     = osType_r;

endmodule

// File: tb/tb_tx_ltssm_os_generator.sv
// Directed bench for tx_ltssm_os_generator; define TX_SKP_INSERT_EN to exercise SKP insertion.
module tb_tx_ltssm_os_generator;
    logic        clk;
    logic        reset;
    logic [2:0]  Gen;
    logic [3:0]  substate;
    logic        start;
    logic [7:0]  linkNumber;
    logic [7:0]  rxLinkNumber;
    logic [4:0]  numberOfDetectedLanes;
    logic [7:0]  rateId;
    logic        directed_speed_change;
    logic        rxDone;
    logic        finish;
    logic [10:0] sentCount;
    int          checks;
    int          errors;

    tx_ltssm_os_generator_if osIf();

    tx_ltssm_os_generator #(
        .DEVICETYPE   (0),
        .POLL_TS1_MIN (1024),
        .POST_RX_MIN  (16)
`ifdef TX_SKP_INSERT_EN
        ,
        .SKP_INTERVAL (4)
`endif
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .Gen                   (Gen),
        .substate              (substate),
        .start                 (start),
        .linkNumber            (linkNumber),
        .rxLinkNumber          (rxLinkNumber),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .rateId                (rateId),
        .directed_speed_change (directed_speed_change),
        .rxDone                (rxDone),
        .finish                (finish),
        .sentCount             (sentCount),
        .osIf                  (osIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; start = 1'b0; Gen = 3'd1; substate = 4'd0;
        linkNumber = 8'h05; rxLinkNumber = 8'hA5; numberOfDetectedLanes = 5'd4;
        rateId = 8'h02; directed_speed_change = 1'b0; rxDone = 1'b0; osIf.os_ready = 1'b0;
        tick(); tick();
        check("rst_valid", osIf.os_valid, 1'b0);
        check("rst_finish", finish, 1'b0);
        check("rst_sent", sentCount, 11'd0);
        check("rst_type", osIf.os_type, 2'd0);
        check("rst_lane0", osIf.orderedSets[127:0], 128'h0);
        reset = 1'b0;

        // Gen3 electrical idle: one EIOS of 0x66 then finish
        Gen = 3'd3; substate = 4'd7; start = 1'b1;
        tick();
        check("eios_load_valid", osIf.os_valid, 1'b0);
        start = 1'b0; osIf.os_ready = 1'b1;
        tick();
        check("eios_valid", osIf.os_valid, 1'b1);
        check("eios_type", osIf.os_type, 2'd2);
        check("eios_lane0", osIf.orderedSets[127:0], {16{8'h66}});
        check("eios_lane3", osIf.orderedSets[3*128 +: 128], {16{8'h66}});
        check("eios_lane4", osIf.orderedSets[4*128 +: 128], 128'h0);
        tick();
        check("eios_finish", finish, 1'b1);
        check("eios_valid_drop", osIf.os_valid, 1'b0);
        check("eios_sent", sentCount, 11'd1);
        tick();
        check("eios_finish_pulse", finish, 1'b0);

        // Non-transmitting substate finishes straight away
        substate = 4'd0; start = 1'b1;
        tick();
        check("nosub_finish", finish, 1'b1);
        check("nosub_valid", osIf.os_valid, 1'b0);
        start = 1'b0;
        tick();
        check("nosub_finish_pulse", finish, 1'b0);
        check("nosub_valid2", osIf.os_valid, 1'b0);
        Gen = 3'd1;

`ifndef TX_SKP_INSERT_EN
        // Polling.Active: 1024 TS1 with rxDone held high
        substate = 4'd1; rxDone = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("poll_type", osIf.os_type, 2'd0);
        check("poll_lane2", osIf.orderedSets[2*128 +: 128], 128'h4A4A4A4A4A4A4A4A4A4A_00_02_FF_F7_F7_BC);
        check("poll_lane4", osIf.orderedSets[4*128 +: 128], 128'h0);
        check("poll_sent0", sentCount, 11'd0);
        repeat (1023) tick();
        check("poll_sent1023", sentCount, 11'd1023);
        check("poll_nofinish", finish, 1'b0);
        check("poll_valid", osIf.os_valid, 1'b1);
        tick();
        check("poll_sent1024", sentCount, 11'd1024);
        check("poll_finish", finish, 1'b1);
        check("poll_valid_drop", osIf.os_valid, 1'b0);
        tick();
        check("poll_finish_pulse", finish, 1'b0);

        // Config.Complete: rxDone after 40 sets, then exactly 16 more TS2
        rxDone = 1'b0; substate = 4'd4; rateId = 8'h03; directed_speed_change = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("cfg_type", osIf.os_type, 2'd1);
        check("cfg_lane2", osIf.orderedSets[2*128 +: 128], 128'h45454545454545454545_00_83_FF_02_05_BC);
        repeat (40) tick();
        check("cfg_sent40", sentCount, 11'd40);
        rxDone = 1'b1;
        repeat (15) tick();
        check("cfg_sent55", sentCount, 11'd55);
        check("cfg_nofinish", finish, 1'b0);
        tick();
        check("cfg_sent56", sentCount, 11'd56);
        check("cfg_finish", finish, 1'b1);
        rxDone = 1'b0; rateId = 8'h02; directed_speed_change = 1'b0;
`endif

        // Recovery.RcvrCfg with a stalling framer, mid-set Gen change, then reset
        substate = 4'd6; osIf.os_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("stall_lane1", osIf.orderedSets[1*128 +: 128], 128'h45454545454545454545_00_02_FF_01_05_BC);
        tick(); tick();
        check("stall_lane1_hold", osIf.orderedSets[1*128 +: 128], 128'h45454545454545454545_00_02_FF_01_05_BC);
        check("stall_sent0", sentCount, 11'd0);
        check("stall_valid", osIf.os_valid, 1'b1);
        osIf.os_ready = 1'b1;
        tick();
        check("stall_sent1", sentCount, 11'd1);
        osIf.os_ready = 1'b0; Gen = 3'd3;
        tick(); tick(); tick();
        check("stall_sent1_hold", sentCount, 11'd1);
        check("gen_old_b0", osIf.orderedSets[135:128], 8'hBC);
        osIf.os_ready = 1'b1;
        tick();
        osIf.os_ready = 1'b0;
        check("stall_sent2", sentCount, 11'd2);
        check("gen_new_b0", osIf.orderedSets[135:128], 8'h2D);
        reset = 1'b1;
        tick();
        check("midrst_valid", osIf.os_valid, 1'b0);
        check("midrst_finish", finish, 1'b0);
        check("midrst_sent", sentCount, 11'd0);
        check("midrst_lane1", osIf.orderedSets[1*128 +: 128], 128'h0);
        check("midrst_type", osIf.os_type, 2'd0);
        reset = 1'b0; Gen = 3'd1;

`ifndef TX_SKP_INSERT_EN
        // Recovery.RcvrLock: restart at 300 sets discards that accept
        substate = 4'd5; osIf.os_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (300) tick();
        check("restart_sent300", sentCount, 11'd300);
        start = 1'b1;
        tick();
        check("restart_sent0", sentCount, 11'd0);
        check("restart_valid_drop", osIf.os_valid, 1'b0);
        start = 1'b0;
        tick();
        check("restart_valid", osIf.os_valid, 1'b1);
        check("restart_sent0b", sentCount, 11'd0);
        rxDone = 1'b1;
        tick();
        check("lock_finish", finish, 1'b1);
        check("lock_sent1", sentCount, 11'd1);
        rxDone = 1'b0;
`else
        // SKP insertion every 4 data sets in Polling.Active
        substate = 4'd1; rxDone = 1'b0; osIf.os_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 9; k++) begin
            check("skp_type", osIf.os_type, (k == 4) ? 2'd3 : 2'd0);
            if (k == 4) begin
                check("skp_lane0", osIf.orderedSets[127:0], 128'h1C1C1CBC);
                check("skp_sent4", sentCount, 11'd4);
            end else if (k == 8) begin
                check("skp_sent7", sentCount, 11'd7);
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
